prog_counter: RTL
=================

Name: prog_counter

Overview:
- Parametrised, loadable up/down counter with a programmable terminal value and three count modes: wrap, saturate and one-shot.
- Emits a registered terminal-count pulse and a one-shot done flag.
- General-purpose timing and sequencing primitive for interval timers, frame and beat counters, and timeout watchdogs in the fabric.
- Next-generation replacement for the fixed 4-bit loadable counter.

Parameters:
- WIDTH, 8, counter, din and limit width in bits (2..32).
- RST_VAL, 0, value of dout after reset; truncated to WIDTH bits.
- PRESCALE_DIV, 4, enable prescale ratio, used only when PROG_COUNTER_PRESCALE_EN is defined (>=1).

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  count enable; one step per cycle while high.
- load  input  1  synchronous load of din.
- din  input  WIDTH  load value.
- up_dn  input  1  1 = count up, 0 = count down.
- mode  input  2  00 = wrap, 01 = saturate, 10 = one-shot, 11 = reserved (behaves as wrap).
- limit  input  WIDTH  terminal value for up counting; sampled every cycle.
- dout  output  WIDTH  registered count.
- tc  output  1  registered terminal-count pulse.
- done  output  1  one-shot complete flag.

Behaviour:
- Interface: reset is reset, synchronous, active-high; clock is clk.
- Reset values: dout = RST_VAL, tc = 0, done = 0, state = RUN.
- Priority each cycle: reset > load > en step > hold.
- Terminal value T: T = limit when up_dn = 1; T = 0 when up_dn = 0.
- Load: dout <= din next cycle; tc <= 0; state <= RUN, done <= 0. Works in any state.
- Step latency: dout updates one cycle after en is sampled high. tc is valid in the same cycle as the new dout.
- Step, dout != T, up, dout < limit: dout + 1.
- Step, dout != T, up, dout > limit: this happens after a load or a limit change.
  - wrap mode: dout <= 0.
  - saturate/one-shot: dout <= limit.
- Step, dout != T, down: dout - 1.
- Step with dout == T:
  - wrap: up -> 0, down -> limit.
  - saturate: hold.
  - one-shot: hold and enter DONE.
- tc:
  - tc = 1 for exactly one cycle whenever an enabled step lands dout on T.
  - No tc on a hold at T.
  - No tc on a wrap away from T.
  - No tc on a load, even when din == T.
- limit == 0, wrap mode, up: dout stays 0 and tc pulses on every enabled step.
- State machine, two states:
  - RUN -> DONE: enabled step in one-shot mode with dout == T.
  - DONE -> RUN: load, reset, or mode leaving 10.
- DONE: done = 1, dout frozen, en ignored, tc = 0.
- Arithmetic: all arithmetic is modulo 2^WIDTH; there is no carry out.
- Direction change mid-count: takes effect on the next step. T is re-evaluated every cycle from the current up_dn and limit.
- Reset mid-operation: overrides load and en in the same cycle. The pending tc is cleared.
- Simultaneous load and en: load wins; no step occurs that cycle.

Optional Feature:
- Macro: PROG_COUNTER_PRESCALE_EN.
- Defined:
  - An internal prescaler of ceil(log2(PRESCALE_DIV)) bits counts en-high cycles.
  - A step occurs only on every PRESCALE_DIV-th en-high cycle.
  - The prescaler clears on reset and on load.
  - The prescaler freezes while en = 0 and while in DONE.
  - Step latency is unchanged relative to the qualifying en cycle.
- Undefined: no prescaler logic; every en-high cycle is a step; PRESCALE_DIV is ignored.

Test Plan:
- WIDTH=4, reset, mode=00, up_dn=1, limit=5, en held 8 cycles -> dout 1,2,3,4,5,0,1,2; tc high only in the cycle dout=5.
- mode=01, up_dn=0, load din=3, then en 5 cycles -> dout 2,1,0,0,0; a single tc pulse in the cycle dout reaches 0.
- mode=10, up_dn=1, limit=2, load 0, en 4 cycles -> dout 1,2,2,2; done=1 from the 4th cycle (dout held at 2); then load 0 -> done=0 and counting resumes.
- mode=00, limit=5, load din=9, up, en 1 cycle -> dout=0, tc=0. Then mode=01, load 9, en 1 cycle -> dout=5, tc=1.
- load=1, en=1, din=7, with reset=1 in the same cycle -> dout=RST_VAL, tc=0. Next cycle load=1, en=1, din=7 -> dout=7, no step that cycle.
- With PROG_COUNTER_PRESCALE_EN defined, PRESCALE_DIV=4, en held 8 cycles, mode=00, limit=15 -> dout increments only after the 4th and 8th cycles (1, then 2). Without the macro -> dout=8.

Source files
------------

// File: rtl/prog_counter.sv
// prog_counter: loadable up/down counter with a programmable terminal value,
// wrap / saturate / one-shot modes, a registered terminal-count pulse and a
// one-shot done flag.
// Optional build macro PROG_COUNTER_PRESCALE_EN: when defined, a step is taken
// only on every PRESCALE_DIV-th enabled cycle.
module prog_counter #(
   parameter int unsigned WIDTH        = 8,
   parameter logic [31:0] RST_VAL      = 32'd0,
   parameter int unsigned PRESCALE_DIV = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             up_dn,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] dout,
   output logic             tc,
   output logic             done
);

   localparam logic [1:0] MODE_SAT  = 2'b01;
   localparam logic [1:0] MODE_ONCE = 2'b10;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_DONE = 1'b1
   } state_e;

   // Elaboration-time parameter range checks.
   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("prog_counter: WIDTH must be in 2..32");
   end
   if (PRESCALE_DIV < 1) begin : g_bad_div
      $error("prog_counter: PRESCALE_DIV must be >= 1");
   end

   logic [WIDTH-1:0] dout_q, dout_d;
   logic             tc_q, tc_d;
   state_e           state_q, state_d;
   logic             step_c;

`ifdef PROG_COUNTER_PRESCALE_EN
   localparam int unsigned PW = (PRESCALE_DIV > 1) ? $clog2(PRESCALE_DIV) : 1;
   localparam logic [PW-1:0] PSC_LAST = PW'(PRESCALE_DIV - 1);

   logic [PW-1:0] psc_q, psc_d;

   // Prescaler: counts enabled RUN cycles, cleared by load, frozen otherwise.
   always_comb begin
      psc_d  = psc_q;
      step_c = 1'b0;
      if (load) begin
         psc_d = '0;
      end else if (en && state_q == ST_RUN) begin
         if (psc_q == PSC_LAST) begin
            psc_d  = '0;
            step_c = 1'b1;
         end else begin
            psc_d = psc_q + PW'(1);
         end
      end
   end

   // Prescaler register.
   always_ff @(posedge clk) begin
      if (reset) psc_q <= '0;
      else       psc_q <= psc_d;
   end
`else
   // Every enabled RUN cycle without a load is a step.
   always_comb begin
      step_c = en && !load && (state_q == ST_RUN);
   end
`endif

   // Next count, terminal-count pulse and one-shot state.
   always_comb begin
      logic [WIDTH-1:0] term;
      logic [WIDTH-1:0] nxt;
      logic             moved;

      dout_d  = dout_q;
      tc_d    = 1'b0;
      state_d = state_q;
      term    = up_dn ? limit : '0;
      nxt     = dout_q;
      moved   = 1'b0;

      if (load) begin
         dout_d  = din;
         state_d = ST_RUN;
      end else if (state_q == ST_DONE) begin
         if (mode != MODE_ONCE) state_d = ST_RUN;
      end else if (step_c) begin
         if (dout_q == term) begin
            // At the terminal value: saturate holds, one-shot finishes,
            // wrap (and reserved) restart from the opposite end.
            if (mode == MODE_ONCE) begin
               state_d = ST_DONE;
            end else if (mode != MODE_SAT) begin
               nxt   = up_dn ? '0 : limit;
               moved = 1'b1;
            end
         end else if (up_dn) begin
            moved = 1'b1;
            if (dout_q < limit)                             nxt = dout_q + WIDTH'(1);
            else if (mode == MODE_SAT || mode == MODE_ONCE) nxt = limit;
            else                                            nxt = '0;
         end else begin
            moved = 1'b1;
            nxt   = dout_q - WIDTH'(1);
         end
         dout_d = nxt;
         tc_d   = moved && (nxt == term);
      end
   end

   // Output and state registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         dout_q  <= WIDTH'(RST_VAL);
         tc_q    <= 1'b0;
         state_q <= ST_RUN;
      end else begin
         dout_q  <= dout_d;
         tc_q    <= tc_d;
         state_q <= state_d;
      end
   end

   assign dout = dout_q;
   assign tc   = tc_q;
   assign done = (state_q == ST_DONE);

endmodule
